spi_frame_tx: RTL and testbench
===============================

Name: spi_frame_tx

Overview:
Parametrised successor to parallel_2_serial. It latches NUM_CH filtered sample words on each filter_done strobe and serialises them to the Raspberry Pi SPI master as one framed transfer: an 8-bit header, then the channel words MSB-first, with an optional CRC trailer. SPI pins are oversampled in the system clock domain. The block sits between the Kalman filter output bank and the rpi_* pins.

Parameters:
NUM_CH, 3, number of channel words per frame (1..8)
DATA_W, 16, bits per channel word (8..32)
CPOL, 0, SCK idle level; the leading edge is the transition away from CPOL
CPHA, 0, 0: sample on leading edge, shift on trailing edge; 1: shift on leading edge, sample on trailing edge

Ports:
clk  in  1  system clock; must be at least 8x the rpi_sck frequency
rst  in  1  synchronous, active-high reset
filtered_data  in  NUM_CH*DATA_W  channel words; channel 0 in the LSBs, sent first
filter_done  in  1  one-cycle strobe; filtered_data is valid this cycle
rpi_sck  in  1  SPI clock from the master, asynchronous
rpi_cs  in  1  SPI chip select from the master, active-low, asynchronous
rpi_miso  out  1  serial data to the master
frame_active  out  1  high from frame load until CS rise
overrun_cnt  out  8  saturating count of staged samples overwritten before being sent

Behaviour:
- Reset values: rpi_miso=0, frame_active=0, overrun_cnt=0, seq=0, staged_valid=0, state=IDLE, staging and shift registers=0.
- Synchronisers:
  - rpi_sck and rpi_cs each pass through a 2-FF synchroniser plus a third FF for edge detection.
  - All edges are detected on synchronised values only.
- Staging:
  - On filter_done, capture filtered_data into the staging register and set staged_valid.
  - If staged_valid was already 1 and not consumed, also increment overrun_cnt, saturating at 255.
- Header byte: {fresh, seq[6:0]}.
  - fresh = staged_valid at load time.
  - If fresh=0, the staging contents are resent unchanged (stale repeat).
- Frame length: L = 8 + NUM_CH*DATA_W bits.
- State machine, states IDLE, LOAD, SHIFT, DONE:
  - IDLE -> LOAD on a synchronised CS fall.
  - LOAD lasts 1 cycle:
    - Shift register = {header, ch0 .. ch(NUM_CH-1)}, MSB-first.
    - Clear staged_valid, set frame_active.
    - rpi_miso = header MSB (drives the first bit for CPHA=0).
    - seq increments mod 128 on every load.
  - SHIFT:
    - On each shift edge, advance to the next bit and increment the bit counter.
    - CPHA=1: the first leading edge presents bit L-1 and is not counted as an advance.
    - After the sample edge of bit 0, go to DONE.
  - DONE: rpi_miso=0; extra SCK edges are ignored.
  - Any state -> IDLE on a synchronised CS rise: frame_active=0, rpi_miso=0.
- Abort: a CS rise before all L bits have been sampled aborts the frame. Staged data that was loaded is considered consumed; there is no retransmit.
- Simultaneous events: a filter_done in the same cycle as LOAD writes staging after the load copy. The loaded frame carries the old data, the new sample leaves staged_valid=1, and overrun_cnt is not incremented.
- rst asserted mid-frame returns the block to reset values immediately; rpi_miso=0.
- While CS is high, rpi_miso=0.

Optional Feature:
SPI_FRAME_CRC_EN
- Defined: an 8-bit CRC is appended after the last channel word, making L = 16 + NUM_CH*DATA_W.
  - Polynomial 0x07, init 0x00, computed over header and data MSB-first.
  - Calculated serially during LOAD/SHIFT, or combinationally at LOAD; either way the value is ready before it is shifted.
- Undefined: no trailer, and no CRC logic is synthesised.

Decomposition:
- Package spi_frame_pkg:
  - state enum (IDLE, LOAD, SHIFT, DONE)
  - HDR_W=8, CRC_W=8, CRC_POLY=8'h07
  - function frame_len(NUM_CH, DATA_W)
- Sub-module sync_edge_det: 2-FF synchroniser with rise/fall pulse outputs. It is instantiated twice, for sck and cs.

Test Plan:
- Default parameters, filter_done with ch0=16'h1234, ch1=16'h5678, ch2=16'h9ABC, then a 56-bit CS-low transfer at SCK=clk/10 -> master receives 8'h80 (fresh=1, seq=0), 1234, 5678, 9ABC; frame_active high throughout; rpi_miso=0 after CS rise.
- Second transfer with no new filter_done -> header 8'h01 (fresh=0, seq=1), same three words repeated.
- Three filter_done strobes with no transfer -> overrun_cnt=2; next frame carries the third sample; 300 strobes with no transfer -> overrun_cnt=255 (saturates).
- CS raised after 20 bits, then a new transfer -> first frame aborted, rpi_miso=0, state IDLE; next header shows seq incremented and fresh per staging.
- filter_done in the same cycle as LOAD -> loaded frame carries the old words; the following frame is fresh with the new words; overrun_cnt unchanged.
- Rerun test 1 with CPOL=1, CPHA=1, and SPI_FRAME_CRC_EN defined -> identical payload; trailer equals CRC-8 0x07 of the 7 preceding bytes, computed by the bench model.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the spi_frame_tx block.
// Build option: define SPI_FRAME_CRC_EN to append a CRC-8 trailer to each frame.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         HDR_W    = 8;
  localparam int         CRC_W    = 8;
  localparam logic [7:0] CRC_POLY = 8'h07;

  // Total bits the master clocks out for one complete frame.
  function automatic int frame_len(input int num_ch, input int data_w);
`ifdef SPI_FRAME_CRC_EN
    return HDR_W + num_ch * data_w + CRC_W;
`else
    return HDR_W + num_ch * data_w;
`endif
  endfunction

`ifdef SPI_FRAME_CRC_EN
  // One bit of an MSB-first CRC-8 update.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic             din);
    logic [CRC_W-1:0] sh;
    sh = {crc[CRC_W-2:0], 1'b0};
    return (crc[CRC_W-1] ^ din) ? (sh ^ CRC_POLY) : sh;
  endfunction
`endif

endpackage

// File: rtl/spi_frame_tx_sync_edge_det.sv
// sync_edge_det: 2-FF synchroniser for an asynchronous pin plus a third
// stage for edge detection; rise/fall are one-cycle pulses in the clk domain.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  // Next values: each stage takes the one before it.
  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and edge-history registers; reset to the pin's idle level
  // so leaving reset does not fake an edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make all three stages update together,
    // so each one holds the previous stage's old value as a real pipeline.
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o =  sync_q & ~prev_q;
  assign fall_o = ~sync_q &  prev_q;

endmodule

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: stages NUM_CH filtered words on filter_done and serves them
// to an SPI master as one frame {header, ch0..chN-1[, crc]} MSB-first.
// Build option: SPI_FRAME_CRC_EN appends a CRC-8 (poly 0x07) trailer.
module spi_frame_tx
  import spi_frame_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 16,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] filtered_data,
  input  logic                     filter_done,
  input  logic                     rpi_sck,
  input  logic                     rpi_cs,
  output logic                     rpi_miso,
  output logic                     frame_active,
  output logic [7:0]               overrun_cnt
);

  localparam int PAY_W  = NUM_CH * DATA_W;
  localparam int BODY_W = HDR_W + PAY_W;
  localparam int L      = frame_len(NUM_CH, DATA_W);
  localparam int CNT_W  = $clog2(L);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic lead_edge, trail_edge, shift_edge, sample_edge;

  sync_edge_det #(.RST_VAL(CPOL != 0)) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(rpi_sck),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(rpi_cs),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Leading edge leaves the CPOL idle level; CPHA picks which edge shifts.
  assign lead_edge   = (CPOL != 0) ? sck_fall : sck_rise;
  assign trail_edge  = (CPOL != 0) ? sck_rise : sck_fall;
  assign shift_edge  = (CPHA != 0) ? lead_edge  : trail_edge;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;

  state_t             state_q, state_d;
  logic [PAY_W-1:0]   stage_q, stage_d;
  logic               staged_valid_q, staged_valid_d;
  logic [7:0]         overrun_q, overrun_d;
  logic [6:0]         seq_q, seq_d;
  logic [L-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               first_q, first_d;
  logic               miso_q, miso_d;
  logic               active_q, active_d;

  logic [BODY_W-1:0]  body;
  logic [L-1:0]       frame_vec;

  // Frame body: header, then channel 0 (staging LSBs) first.
  always_comb begin
    body = '0;
    body[PAY_W +: HDR_W] = {staged_valid_q, seq_q};
    for (int i = 0; i < NUM_CH; i++) begin
      body[(NUM_CH-1-i)*DATA_W +: DATA_W] = stage_q[i*DATA_W +: DATA_W];
    end
  end

`ifdef SPI_FRAME_CRC_EN
  logic [CRC_W-1:0] crc;

  // CRC over header and data, fully combinational so it is ready at LOAD.
  always_comb begin
    crc = '0;
    for (int i = BODY_W - 1; i >= 0; i--) begin
      crc = crc8_step(crc, body[i]);
    end
  end

  assign frame_vec = {body, crc};
`else
  assign frame_vec = body;
`endif

  // Next-state logic: frame FSM, then CS-rise override, then staging writes.
  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a value unassigned,
    // which is what keeps this block from inferring latches.
    state_d        = state_q;
    stage_d        = stage_q;
    staged_valid_d = staged_valid_q;
    overrun_d      = overrun_q;
    seq_d          = seq_q;
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    first_d        = first_q;
    miso_d         = miso_q;
    active_d       = active_q;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        shreg_d        = frame_vec;
        miso_d         = frame_vec[L-1];
        bit_cnt_d      = '0;
        first_d        = 1'b1;
        active_d       = 1'b1;
        staged_valid_d = 1'b0;
        seq_d          = seq_q + 7'd1;
        state_d        = SHIFT;
      end
      SHIFT: begin
        if (shift_edge) begin
          if ((CPHA != 0) && first_q) begin
            // CPHA=1: first leading edge only presents the MSB.
            first_d = 1'b0;
            miso_d  = shreg_q[L-1];
          end else begin
            shreg_d   = shreg_q << 1;
            miso_d    = shreg_q[L-2];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        if (sample_edge && (bit_cnt_q == CNT_W'(L - 1))) begin
          state_d = DONE;
          miso_d  = 1'b0;
        end
      end
      DONE: begin
        miso_d = 1'b0;
      end
    endcase

    // CS rise ends or aborts the frame from any state.
    if (cs_rise) begin
      state_d  = IDLE;
      miso_d   = 1'b0;
      active_d = 1'b0;
    end

    // A new sample lands after any LOAD copy; only a true overwrite counts.
    if (filter_done) begin
      if (staged_valid_q && (state_q != LOAD) && (overrun_q != 8'hFF)) begin
        overrun_d = overrun_q + 8'd1;
      end
      stage_d        = filtered_data;
      staged_valid_d = 1'b1;
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      stage_q        <= '0;
      staged_valid_q <= 1'b0;
      overrun_q      <= '0;
      seq_q          <= '0;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      first_q        <= 1'b0;
      miso_q         <= 1'b0;
      active_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      stage_q        <= stage_d;
      staged_valid_q <= staged_valid_d;
      overrun_q      <= overrun_d;
      seq_q          <= seq_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      first_q        <= first_d;
      miso_q         <= miso_d;
      active_q       <= active_d;
    end
  end

  // The raw CS gate keeps MISO low the moment CS goes high, without waiting
  // for the synchroniser to catch up.
  assign rpi_miso     = miso_q & ~rpi_cs;
  assign frame_active = active_q;
  assign overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: an SPI master task drives CS/SCK and
// collects MISO bits; a byte-level frame model predicts each transfer.
module tb_spi_frame_tx;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int HALF   = 5;   // SCK half period in clk cycles (SCK = clk/10)
`ifdef SPI_FRAME_CRC_EN
  localparam int CPOL = 1;
  localparam int CPHA = 1;
  localparam int LT   = 64;
`else
  localparam int CPOL = 0;
  localparam int CPHA = 0;
  localparam int LT   = 56;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] filtered_data;
  logic        filter_done;
  logic        rpi_sck;
  logic        rpi_cs;
  logic        rpi_miso;
  logic        frame_active;
  logic [7:0]  overrun_cnt;

  always #5 clk = ~clk;

  spi_frame_tx #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .CPOL  (CPOL),
    .CPHA  (CPHA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .filtered_data(filtered_data),
    .filter_done  (filter_done),
    .rpi_sck      (rpi_sck),
    .rpi_cs       (rpi_cs),
    .rpi_miso     (rpi_miso),
    .frame_active (frame_active),
    .overrun_cnt  (overrun_cnt)
  );

  typedef struct {
    logic [63:0] bits;
    int          nbits;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t rx_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  // Reference model state.
  logic [15:0] m_words[NUM_CH];
  bit          m_valid;
  int          m_seq;
  int          m_ovr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) m_words[i] = '0;
    m_valid = 1'b0;
    m_seq   = 0;
    m_ovr   = 0;
  endfunction

  function automatic void model_strobe(input logic [47:0] d);
    if (m_valid && m_ovr < 255) m_ovr++;
    for (int i = 0; i < NUM_CH; i++) m_words[i] = d[i*16 +: 16];
    m_valid = 1'b1;
  endfunction

  // Builds the frame as a byte list, appends the CRC when enabled, and
  // queues the first nbits the master is expected to see.
  function automatic void model_load(input int nbits);
    logic [7:0]  bytes[1 + 2*NUM_CH];
    logic [63:0] f;
    logic [7:0]  crc;
    xfer_t       e;
    bytes[0] = {m_valid, 7'(m_seq % 128)};
    for (int c = 0; c < NUM_CH; c++) begin
      bytes[1 + 2*c] = m_words[c][15:8];
      bytes[2 + 2*c] = m_words[c][7:0];
    end
    f   = '0;
    crc = '0;
    for (int k = 0; k < 1 + 2*NUM_CH; k++) begin
      f = (f << 8) | 64'(bytes[k]);
      crc = crc ^ bytes[k];
      for (int b = 0; b < 8; b++) crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
    end
`ifdef SPI_FRAME_CRC_EN
    f = (f << 8) | 64'(crc);
`endif
    e.bits  = f >> (LT - nbits);
    e.nbits = nbits;
    exp_q.push_back(e);
    m_valid = 1'b0;
    m_seq   = (m_seq + 1) % 128;
  endfunction

  task automatic strobe(input logic [47:0] d);
    filtered_data = d;
    filter_done   = 1'b1;
    @(negedge clk);
    filter_done   = 1'b0;
    model_strobe(d);
  endtask

  function automatic logic [47:0] rand48();
    logic [47:0] d;
    d = {16'($urandom), 32'($urandom)};
    return d;
  endfunction

  // One CS-low transfer of nbits; optionally fires filter_done in the LOAD
  // cycle (CS fall + 2 sync stages + 1 cycle to enter LOAD).
  task automatic spi_xfer(input int nbits, input bit strobe_at_load, input logic [47:0] sdata);
    xfer_t r;
    r.bits  = '0;
    r.nbits = nbits;
    model_load(nbits);
    rpi_cs = 1'b0;
    if (strobe_at_load) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      strobe(sdata);
    end
    repeat (2*HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (CPHA == 0) r.bits = {r.bits[62:0], rpi_miso};
      rpi_sck = (CPOL == 0);
      repeat (HALF) @(negedge clk);
      if (CPHA != 0) r.bits = {r.bits[62:0], rpi_miso};
      rpi_sck = (CPOL != 0);
      repeat (HALF) @(negedge clk);
      if (i == nbits / 2) check("frame_active_mid", 64'(frame_active), 64'd1);
    end
    rpi_cs = 1'b1;
    rx_q.push_back(r);
    repeat (2*HALF) @(negedge clk);
    check("miso_after_cs", 64'(rpi_miso), 64'd0);
    check("active_after_cs", 64'(frame_active), 64'd0);
  endtask

  // Monitor: each received frame is matched against the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      while (rx_q.size() > 0) begin
        xfer_t r;
        xfer_t e;
        r = rx_q.pop_front();
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_unexpected: got %h expected none", r.bits);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("frame%0d_%0db", n_frames, r.nbits), r.bits, e.bits);
        end
        n_frames++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] d;
    int          k;
    rst           = 1'b1;
    rpi_cs        = 1'b1;
    rpi_sck       = (CPOL != 0);
    filter_done   = 1'b0;
    filtered_data = '0;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_miso", 64'(rpi_miso), 64'd0);
    check("rst_active", 64'(frame_active), 64'd0);
    check("rst_overrun", 64'(overrun_cnt), 64'd0);

    // Directed frame, then a stale repeat.
    strobe(48'h9ABC_5678_1234);
    spi_xfer(LT, 1'b0, '0);
    spi_xfer(LT, 1'b0, '0);

    // Overwrites without a transfer.
    for (int i = 0; i < 3; i++) strobe(rand48());
    check("overrun_3", 64'(overrun_cnt), 64'(m_ovr));
    spi_xfer(LT, 1'b0, '0);

    // Abort after 20 bits, then a full frame (stale, seq advanced).
    strobe(rand48());
    spi_xfer(20, 1'b0, '0);
    spi_xfer(LT, 1'b0, '0);

    // filter_done coinciding with LOAD.
    strobe(rand48());
    d = rand48();
    spi_xfer(LT, 1'b1, d);
    check("overrun_sim", 64'(overrun_cnt), 64'(m_ovr));
    spi_xfer(LT, 1'b0, '0);

    // Randomised mix of strobes, full frames and aborts.
    for (int it = 0; it < 6; it++) begin
      k = $urandom_range(0, 2);
      for (int s = 0; s < k; s++) strobe(rand48());
      check("overrun_rand", 64'(overrun_cnt), 64'(m_ovr));
      if ($urandom_range(0, 3) == 0) spi_xfer($urandom_range(9, LT - 1), 1'b0, '0);
      else                           spi_xfer(LT, 1'b0, '0);
    end

    // Saturation.
    for (int i = 0; i < 300; i++) strobe(rand48());
    check("overrun_sat", 64'(overrun_cnt), 64'(m_ovr));

    // Reset in the middle of a frame.
    rpi_cs = 1'b0;
    repeat (20) @(negedge clk);
    check("active_before_rst", 64'(frame_active), 64'd1);
    rst    = 1'b1;
    rpi_cs = 1'b1;
    @(negedge clk);
    check("midrst_miso", 64'(rpi_miso), 64'd0);
    check("midrst_active", 64'(frame_active), 64'd0);
    check("midrst_overrun", 64'(overrun_cnt), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    strobe(48'h9ABC_5678_1234);
    spi_xfer(LT, 1'b0, '0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
